// File: rtl/battleship_pkg.sv
// battleship_pkg: board geometry defaults, coordinate/counter types and the
// placement FSM states shared by the ship placer and its cursor logic.
package battleship_pkg;

    localparam int GRID_SIZE = 5;
    localparam int NUM_SHIPS = 5;

    typedef logic [2:0] coord_t;
    typedef logic [2:0] count_t;

    typedef enum logic {
        PLACE = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/ship_placer_if.sv
// ship_placer_if: controller enables, button pulses, PC shots and the
// registered board/status view of the ship placer, bundled as one port.
interface ship_placer_if #(
    parameter int GRID_SIZE = battleship_pkg::GRID_SIZE
);

    logic                           en_put_barcos;
    logic                           en_move;
    logic                           btn_up;
    logic                           btn_down;
    logic                           btn_left;
    logic                           btn_right;
    logic                           btn_place;
    logic                           shot_valid;
    battleship_pkg::coord_t         shot_x;
    battleship_pkg::coord_t         shot_y;
    battleship_pkg::coord_t         cursor_x;
    battleship_pkg::coord_t         cursor_y;
    battleship_pkg::count_t         barcos_put;
    battleship_pkg::count_t         hp_player;
    logic [GRID_SIZE*GRID_SIZE-1:0] board;
    logic                           place_err;
    logic                           shot_hit;
    logic                           shot_miss;

    modport master (
        output en_put_barcos, en_move,
        output btn_up, btn_down, btn_left, btn_right, btn_place,
        output shot_valid, shot_x, shot_y,
        input  cursor_x, cursor_y, barcos_put, hp_player, board,
        input  place_err, shot_hit, shot_miss
    );

    modport slave (
        input  en_put_barcos, en_move,
        input  btn_up, btn_down, btn_left, btn_right, btn_place,
        input  shot_valid, shot_x, shot_y,
        output cursor_x, cursor_y, barcos_put, hp_player, board,
        output place_err, shot_hit, shot_miss
    );

endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: board cursor. Picks at most one move per cycle (place beats
// every move, then up > down > left > right) and clamps at the board edges.
module cursor_ctrl #(
    parameter int GRID_SIZE = battleship_pkg::GRID_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_move,
    input  logic                   btn_place,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    output battleship_pkg::coord_t cursor_x,
    output battleship_pkg::coord_t cursor_y
);

    import battleship_pkg::*;

    localparam coord_t MAX_COORD = coord_t'(GRID_SIZE - 1);

    coord_t x_next;
    coord_t y_next;

    // Choose the single winning move; an edge-crossing move leaves the cursor put.
    always_comb begin
        x_next = cursor_x;
        y_next = cursor_y;
        if (en_move && !btn_place) begin
            if (btn_up) begin
                if (cursor_y != '0) y_next = cursor_y - 3'd1;
            end else if (btn_down) begin
                if (cursor_y < MAX_COORD) y_next = cursor_y + 3'd1;
            end else if (btn_left) begin
                if (cursor_x != '0) x_next = cursor_x - 3'd1;
            end else if (btn_right) begin
                if (cursor_x < MAX_COORD) x_next = cursor_x + 3'd1;
            end
        end
    end

    // Cursor register, homed to the top-left cell on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            cursor_x <= x_next;
            cursor_y <= y_next;
        end
    end

endmodule

// File: rtl/ship_placer.sv
// ship_placer: lets the player drop single-cell ships on the board, then
// takes PC shots against the finished board. All outputs are registered.
module ship_placer #(
    parameter int GRID_SIZE = battleship_pkg::GRID_SIZE,
    parameter int NUM_SHIPS = battleship_pkg::NUM_SHIPS
) (
    input logic         clk,
    input logic         reset,
    ship_placer_if.slave bus
);

    import battleship_pkg::*;

    localparam int     CELLS     = GRID_SIZE * GRID_SIZE;
    localparam int     IDX_W     = $clog2(CELLS);
    localparam coord_t MAX_COORD = coord_t'(GRID_SIZE - 1);
    localparam count_t SHIPS     = count_t'(NUM_SHIPS);

    typedef logic [IDX_W-1:0] idx_t;

    // Row-major cell number, matching the board bitmap layout.
    function automatic idx_t cell_index(coord_t x, coord_t y);
        return idx_t'(int'(y) * GRID_SIZE + int'(x));
    endfunction

    state_t           state;
    state_t           state_next;
    coord_t           cursor_x;
    coord_t           cursor_y;
    logic [CELLS-1:0] board_q;
    count_t           barcos_q;
    count_t           hp_q;
    logic             place_err_q;
    logic             shot_hit_q;
    logic             shot_miss_q;

    logic place_accept;
    logic shot_active;
    logic shot_in_grid;
    idx_t place_idx;
    idx_t shot_idx;

    assign place_idx    = cell_index(cursor_x, cursor_y);
    assign shot_idx     = cell_index(bus.shot_x, bus.shot_y);
    assign place_accept = bus.btn_place && (state == PLACE) && bus.en_put_barcos && (barcos_q != '0);
    assign shot_active  = bus.shot_valid && (state == ARMED);
    assign shot_in_grid = (bus.shot_x <= MAX_COORD) && (bus.shot_y <= MAX_COORD);

    cursor_ctrl #(
        .GRID_SIZE (GRID_SIZE)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .en_move   (bus.en_move),
        .btn_place (bus.btn_place),
        .btn_up    (bus.btn_up),
        .btn_down  (bus.btn_down),
        .btn_left  (bus.btn_left),
        .btn_right (bus.btn_right),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    // Phase register: placing until the last ship lands, then armed until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PLACE;
        else       state <= state_next;
    end

    // Arm one cycle after the ships-to-place counter has reached zero.
    always_comb begin
        state_next = state;
        if ((state == PLACE) && (barcos_q == '0)) state_next = ARMED;
    end

    // Board, counters and one-cycle status pulses; placement and shots never overlap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board_q     <= '0;
            barcos_q    <= SHIPS;
            hp_q        <= '0;
            place_err_q <= 1'b0;
            shot_hit_q  <= 1'b0;
            shot_miss_q <= 1'b0;
        end else begin
            place_err_q <= 1'b0;
            shot_hit_q  <= 1'b0;
            shot_miss_q <= 1'b0;
            if (place_accept) begin
                if (board_q[place_idx]) begin
                    place_err_q <= 1'b1;
                end else begin
                    board_q[place_idx] <= 1'b1;
                    barcos_q           <= barcos_q - 3'd1;
                    hp_q               <= hp_q + 3'd1;
                end
            end
            if (shot_active) begin
                if (shot_in_grid && board_q[shot_idx]) begin
                    board_q[shot_idx] <= 1'b0;
                    if (hp_q != '0) hp_q <= hp_q - 3'd1;
                    shot_hit_q <= 1'b1;
                end else begin
                    shot_miss_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cursor_x   = cursor_x;
    assign bus.cursor_y   = cursor_y;
    assign bus.barcos_put = barcos_q;
    assign bus.hp_player  = hp_q;
    assign bus.board      = board_q;
    assign bus.place_err  = place_err_q;
    assign bus.shot_hit   = shot_hit_q;
    assign bus.shot_miss  = shot_miss_q;

endmodule

// File: tb/tb_ship_placer.sv
// tb_ship_placer: directed vector table for cursor moves, placement and
// shots, followed by hand-written reset corner cases.
module tb_ship_placer;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_P    = 5'b10000;
    localparam logic [4:0] B_U    = 5'b01000;
    localparam logic [4:0] B_D    = 5'b00100;
    localparam logic [4:0] B_L    = 5'b00010;
    localparam logic [4:0] B_R    = 5'b00001;
    localparam int         NVEC   = 36;

    typedef struct {
        logic        en_move;
        logic        en_put;
        logic [4:0]  btn;
        logic        shot_v;
        logic [2:0]  sx;
        logic [2:0]  sy;
        logic [2:0]  ecx;
        logic [2:0]  ecy;
        logic [2:0]  ebar;
        logic [2:0]  ehp;
        logic [2:0]  epulse;
        logic [24:0] eboard;
    } vec_t;

    logic clk;
    logic reset;
    int   pass_count;
    int   check_count;
    vec_t vecs [NVEC];

    ship_placer_if #(.GRID_SIZE(5)) bus ();

    ship_placer #(
        .GRID_SIZE (5),
        .NUM_SHIPS (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic em, input logic ep, input logic [4:0] b,
                                input logic sv, input logic [2:0] sx, input logic [2:0] sy,
                                input logic [2:0] ecx, input logic [2:0] ecy,
                                input logic [2:0] ebar, input logic [2:0] ehp,
                                input logic [2:0] epul, input logic [24:0] eb);
        vec_t v;
        v.en_move = em;  v.en_put = ep;  v.btn = b;
        v.shot_v  = sv;  v.sx = sx;      v.sy = sy;
        v.ecx     = ecx; v.ecy = ecy;    v.ebar = ebar;
        v.ehp     = ehp; v.epulse = epul; v.eboard = eb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int row,
                               input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    endtask

    task automatic checkState(input int row, input logic [2:0] cx, input logic [2:0] cy,
                              input logic [2:0] bar, input logic [2:0] hp,
                              input logic [2:0] pul, input logic [24:0] brd);
        checkOutput("cursor_x",   row, 32'(bus.cursor_x),   32'(cx));
        checkOutput("cursor_y",   row, 32'(bus.cursor_y),   32'(cy));
        checkOutput("barcos_put", row, 32'(bus.barcos_put), 32'(bar));
        checkOutput("hp_player",  row, 32'(bus.hp_player),  32'(hp));
        checkOutput("pulses",     row, 32'({bus.place_err, bus.shot_hit, bus.shot_miss}), 32'(pul));
        checkOutput("board",      row, 32'(bus.board),      32'(brd));
    endtask

    task automatic clearInputs();
        bus.en_put_barcos = 1'b0;
        bus.en_move       = 1'b0;
        {bus.btn_place, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = B_NONE;
        bus.shot_valid    = 1'b0;
        bus.shot_x        = '0;
        bus.shot_y        = '0;
    endtask

    // Drive one vector at the falling edge and return just after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.en_move       = v.en_move;
        bus.en_put_barcos = v.en_put;
        {bus.btn_place, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = v.btn;
        bus.shot_valid    = v.shot_v;
        bus.shot_x        = v.sx;
        bus.shot_y        = v.sy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        reset       = 1'b1;
        clearInputs();

        //            em ep btn        sv sx sy   cx cy bar hp pulse   board
        vecs[0]  = mk(1, 0, B_R,       0, 0, 0,   1, 0, 5, 0, 3'b000, 25'h0);
        vecs[1]  = mk(1, 0, B_R,       0, 0, 0,   2, 0, 5, 0, 3'b000, 25'h0);
        vecs[2]  = mk(1, 0, B_R,       0, 0, 0,   3, 0, 5, 0, 3'b000, 25'h0);
        vecs[3]  = mk(1, 0, B_R,       0, 0, 0,   4, 0, 5, 0, 3'b000, 25'h0);
        vecs[4]  = mk(1, 0, B_R,       0, 0, 0,   4, 0, 5, 0, 3'b000, 25'h0);
        vecs[5]  = mk(1, 0, B_R,       0, 0, 0,   4, 0, 5, 0, 3'b000, 25'h0);
        vecs[6]  = mk(0, 0, B_L,       0, 0, 0,   4, 0, 5, 0, 3'b000, 25'h0);
        vecs[7]  = mk(1, 0, B_U,       0, 0, 0,   4, 0, 5, 0, 3'b000, 25'h0);
        vecs[8]  = mk(1, 0, B_L|B_R,   0, 0, 0,   3, 0, 5, 0, 3'b000, 25'h0);
        vecs[9]  = mk(1, 0, B_P,       0, 0, 0,   3, 0, 5, 0, 3'b000, 25'h0);
        vecs[10] = mk(1, 0, B_D|B_L|B_R, 0, 0, 0, 3, 1, 5, 0, 3'b000, 25'h0);
        vecs[11] = mk(1, 0, B_L,       0, 0, 0,   2, 1, 5, 0, 3'b000, 25'h0);
        vecs[12] = mk(1, 0, B_L,       0, 0, 0,   1, 1, 5, 0, 3'b000, 25'h0);
        vecs[13] = mk(1, 0, B_L,       0, 0, 0,   0, 1, 5, 0, 3'b000, 25'h0);
        vecs[14] = mk(1, 0, B_U,       0, 0, 0,   0, 0, 5, 0, 3'b000, 25'h0);
        vecs[15] = mk(1, 1, B_P,       0, 0, 0,   0, 0, 4, 1, 3'b000, 25'h1);
        vecs[16] = mk(1, 1, B_P,       0, 0, 0,   0, 0, 4, 1, 3'b100, 25'h1);
        vecs[17] = mk(1, 0, B_R,       0, 0, 0,   1, 0, 4, 1, 3'b000, 25'h1);
        vecs[18] = mk(1, 0, B_D,       0, 0, 0,   1, 1, 4, 1, 3'b000, 25'h1);
        vecs[19] = mk(1, 1, B_P|B_D,   0, 0, 0,   1, 1, 3, 2, 3'b000, 25'h41);
        vecs[20] = mk(1, 0, B_R,       0, 0, 0,   2, 1, 3, 2, 3'b000, 25'h41);
        vecs[21] = mk(1, 0, B_D,       0, 0, 0,   2, 2, 3, 2, 3'b000, 25'h41);
        vecs[22] = mk(1, 0, B_D,       0, 0, 0,   2, 3, 3, 2, 3'b000, 25'h41);
        vecs[23] = mk(1, 1, B_P,       0, 0, 0,   2, 3, 2, 3, 3'b000, 25'h20041);
        vecs[24] = mk(1, 0, B_NONE,    1, 2, 3,   2, 3, 2, 3, 3'b000, 25'h20041);
        vecs[25] = mk(1, 0, B_U,       0, 0, 0,   2, 2, 2, 3, 3'b000, 25'h20041);
        vecs[26] = mk(1, 1, B_P,       0, 0, 0,   2, 2, 1, 4, 3'b000, 25'h21041);
        vecs[27] = mk(1, 0, B_U,       0, 0, 0,   2, 1, 1, 4, 3'b000, 25'h21041);
        vecs[28] = mk(1, 1, B_P,       0, 0, 0,   2, 1, 0, 5, 3'b000, 25'h210C1);
        vecs[29] = mk(1, 1, B_P,       0, 0, 0,   2, 1, 0, 5, 3'b000, 25'h210C1);
        vecs[30] = mk(0, 0, B_NONE,    1, 2, 3,   2, 1, 0, 4, 3'b010, 25'h010C1);
        vecs[31] = mk(0, 0, B_NONE,    1, 2, 3,   2, 1, 0, 4, 3'b001, 25'h010C1);
        vecs[32] = mk(0, 0, B_NONE,    1, 7, 7,   2, 1, 0, 4, 3'b001, 25'h010C1);
        vecs[33] = mk(1, 0, B_D,       1, 0, 0,   2, 2, 0, 3, 3'b010, 25'h010C0);
        vecs[34] = mk(0, 0, B_NONE,    1, 4, 0,   2, 2, 0, 3, 3'b001, 25'h010C0);
        vecs[35] = mk(1, 1, B_P,       0, 0, 0,   2, 2, 0, 3, 3'b000, 25'h010C0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkState(-1, 3'd0, 3'd0, 3'd5, 3'd0, 3'b000, 25'h0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkState(i, vecs[i].ecx, vecs[i].ecy, vecs[i].ebar, vecs[i].ehp,
                       vecs[i].epulse, vecs[i].eboard);
        end

        // Reset held across the edge where an accepted place would land.
        @(negedge clk);
        clearInputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.en_put_barcos = 1'b1;
        bus.btn_place     = 1'b1;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkState(100, 3'd0, 3'd0, 3'd5, 3'd0, 3'b000, 25'h0);

        // Placing works again once reset is released.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkState(101, 3'd0, 3'd0, 3'd4, 3'd1, 3'b000, 25'h1);

        // Asynchronous reset clears state between clock edges.
        @(negedge clk);
        clearInputs();
        #2;
        reset = 1'b1;
        #1;
        checkState(102, 3'd0, 3'd0, 3'd5, 3'd0, 3'b000, 25'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ship_placer.md
SHIP_PLACER -- requirements
Module: ship_placer

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 5, meaning board side length in cells.
REQ-002 SHALL have parameter NUM_SHIPS, default 5, meaning single-cell ships to place; must be ≤7.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en_put_barcos  input  1  placement enable from game controller.
REQ-006 SHALL have port en_move  input  1  cursor-movement enable from game controller.
REQ-007 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_place  input  1 each  debounced single-cycle pulses.
REQ-008 SHALL have ports shot_valid  input  1, shot_x and shot_y  input  3 each  PC shot at the player board.
REQ-009 SHALL have ports cursor_x and cursor_y  output  3 each  current cursor cell.
REQ-010 SHALL have port barcos_put  output  3  ships still to place.
REQ-011 SHALL have port hp_player  output  3  player ships placed and not yet hit.
REQ-012 SHALL have port board  output  GRID_SIZE*GRID_SIZE  occupancy bitmap; bit index y*GRID_SIZE+x.
REQ-013 SHALL have ports place_err, shot_hit, shot_miss  output  1 each  single-cycle status pulses.

Function
REQ-014 SHALL use two internal states: PLACE, entered on reset, and ARMED.
REQ-015 SHALL move PLACE→ARMED in the cycle after barcos_put becomes 0; ARMED is left only by reset.
REQ-016 SHALL act on at most one button per cycle, with priority btn_place > up > down > left > right; lower-priority buttons in the same cycle are dropped.
REQ-017 SHALL move the cursor only while en_move=1: up decrements y, down increments y, left decrements x, right increments x.
REQ-018 SHALL clamp the cursor at 0 and GRID_SIZE-1 with no wrap-around; a move past an edge leaves the cursor unchanged.
REQ-019 SHALL accept btn_place only when state is PLACE, en_put_barcos=1 and barcos_put>0; otherwise btn_place is ignored and produces no pulse.
REQ-020 SHALL, on an accepted place to an empty cell, on the next edge set the board bit, decrement barcos_put and increment hp_player.
REQ-021 SHALL, on an accepted place to an occupied cell, leave board and counters unchanged and pulse place_err for one cycle.
REQ-022 SHALL evaluate shot_valid only when state is ARMED; shots in PLACE are ignored.
REQ-023 SHALL, on a shot to an occupied cell, clear that bit, decrement hp_player and pulse shot_hit on the next edge; on an empty or out-of-grid cell it SHALL pulse shot_miss only.
REQ-024 SHALL never drive hp_player below 0 or barcos_put above NUM_SHIPS.
REQ-025 SHALL produce all outputs from registers with one-cycle latency from the input event.
REQ-026 SHALL process a shot and a button in the same cycle independently; only cursor movement can coincide with a shot, since placement is blocked in ARMED.

Reset
REQ-027 SHALL, on reset, asynchronously set cursor to (0,0), barcos_put=NUM_SHIPS, hp_player=0, board=0, all pulses=0 and state=PLACE.
REQ-028 SHALL abort any placement or shot in progress when reset asserts mid-operation, with no partial update.

Structure
REQ-029 SHALL take GRID_SIZE, NUM_SHIPS, the coordinate type and the state enum from the shared package battleship_pkg.
REQ-030 SHALL place cursor priority, clamping and movement in one sub-module, cursor_ctrl.

Verification
REQ-031 SHALL cover: reset, then btn_right ×6 with en_move=1 -> cursor_x=4 (clamped), cursor_y=0.
REQ-032 SHALL cover: place at (0,0), then place again at (0,0) -> barcos_put 5→4, then place_err pulse with barcos_put still 4.
REQ-033 SHALL cover: btn_place and btn_down in the same cycle at (1,1) -> bit 6 set and cursor_y still 1.
REQ-034 SHALL cover: 5 placements -> barcos_put=0, hp_player=5, ARMED; a sixth btn_place causes no change and no pulse.
REQ-035 SHALL cover: in ARMED, shot at an occupied (2,3) -> shot_hit, bit 17 cleared, hp_player 5→4; repeat the same shot -> shot_miss.
REQ-036 SHALL cover: reset asserted in the same cycle as an accepted btn_place -> board=0 and barcos_put=5.
